// File: rtl/id_reorder_buffer.sv
// Reorder buffer: tags are allocated in order, completions land in any order,
// and completed entries drain strictly in allocation order.

module id_rob_entry #(
  parameter type data_t = logic [31:0]
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  alloc_set,
  input  logic  pop_clr,
  input  logic  wr_en,
  input  data_t wr_data,
  output logic  alloc_q,
  output logic  done_q,
  output data_t data_q
);

  // Allocation beats the pop clear so a slot freed and reused in one cycle
  // comes back allocated and not done.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      alloc_q <= 1'b0;
      done_q  <= 1'b0;
    end else if (alloc_set) begin
      alloc_q <= 1'b1;
      done_q  <= 1'b0;
    end else if (pop_clr) begin
      alloc_q <= 1'b0;
      done_q  <= 1'b0;
    end else if (wr_en) begin
      done_q  <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) data_q <= wr_data;
  end

endmodule

module id_reorder_buffer #(
  parameter int unsigned CAPACITY = 8,
  parameter bit          FULL_BW  = 1'b0,
  parameter type         data_t   = logic [31:0],
  localparam int unsigned TagWidth = (CAPACITY > 1) ? $clog2(CAPACITY) : 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                alloc_req_i,
  output logic                alloc_gnt_o,
  output logic [TagWidth-1:0] alloc_tag_o,
  input  logic                wr_valid_i,
  input  logic [TagWidth-1:0] wr_tag_i,
  input  data_t               wr_data_i,
  output logic                wr_err_o,
  output logic                oup_valid_o,
  input  logic                oup_ready_i,
  output logic [TagWidth-1:0] oup_tag_o,
  output data_t               oup_data_o,
  output logic [TagWidth:0]   usage_o,
  output logic                full_o,
  output logic                empty_o
);

  localparam logic [TagWidth:0]   CapW    = CAPACITY[TagWidth:0];
  localparam logic [TagWidth-1:0] LastTag = CAPACITY[TagWidth-1:0] - 1'b1;

  logic [TagWidth-1:0] alloc_ptr_q, head_ptr_q;
  logic [TagWidth:0]   usage_q;
  logic [CAPACITY-1:0] alloc_vec, done_vec;
  data_t               data_vec [CAPACITY];

  logic wr_in_range, wr_legal, wr_en, pop, gnt;

  assign empty_o = (usage_q == '0);
  assign full_o  = (usage_q == CapW);
  assign usage_o = usage_q;

  assign oup_valid_o = !empty_o && done_vec[head_ptr_q];
  assign oup_tag_o   = head_ptr_q;
  assign oup_data_o  = oup_valid_o ? data_vec[head_ptr_q] : '0;
  assign pop         = oup_valid_o && oup_ready_i;

  assign gnt         = alloc_req_i && (!full_o || (FULL_BW && pop));
  assign alloc_gnt_o = gnt;
  assign alloc_tag_o = alloc_ptr_q;

  // Same-cycle writes to the slot being allocated or the head being popped
  // fall out as illegal: the former is unallocated, the latter already done.
  assign wr_in_range = ({1'b0, wr_tag_i} < CapW);
  assign wr_legal    = wr_in_range && alloc_vec[wr_tag_i] && !done_vec[wr_tag_i];
  assign wr_en       = wr_valid_i && wr_legal;
  assign wr_err_o    = wr_valid_i && !wr_legal;

  for (genvar i = 0; i < CAPACITY; i++) begin : g_entry
    localparam logic [TagWidth-1:0] Sel = TagWidth'(i);
    id_rob_entry #(.data_t(data_t)) u_entry (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .alloc_set (gnt && (alloc_ptr_q == Sel)),
      .pop_clr   (pop && (head_ptr_q == Sel)),
      .wr_en     (wr_en && (wr_tag_i == Sel)),
      .wr_data   (wr_data_i),
      .alloc_q   (alloc_vec[i]),
      .done_q    (done_vec[i]),
      .data_q    (data_vec[i])
    );
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      alloc_ptr_q <= '0;
      head_ptr_q  <= '0;
      usage_q     <= '0;
    end else begin
      if (gnt) alloc_ptr_q <= (alloc_ptr_q == LastTag) ? '0 : alloc_ptr_q + 1'b1;
      if (pop) head_ptr_q  <= (head_ptr_q  == LastTag) ? '0 : head_ptr_q  + 1'b1;
      if (gnt && !pop)      usage_q <= usage_q + 1'b1;
      else if (!gnt && pop) usage_q <= usage_q - 1'b1;
    end
  end

`ifndef SYNTHESIS
  if (CAPACITY < 1) begin : g_cap_chk
    $error("id_reorder_buffer: CAPACITY must be >= 1");
  end

  usage_bound: assert property (@(posedge clk_i) disable iff (!rst_ni) usage_q <= CapW);
  no_pop_empty: assert property (@(posedge clk_i) disable iff (!rst_ni) !(pop && empty_o));
`endif

endmodule

// File: tb/tb_id_reorder_buffer.sv
// Bench for id_reorder_buffer: two instances (CAPACITY 8/FULL_BW 0 and
// CAPACITY 5/FULL_BW 1) checked every cycle against an in-order list model.

module tb_id_reorder_buffer;

  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] req, gnt, wr, err, ready, ovld, full, empty;
  logic [1:0][2:0]  atag, wtag, otag;
  logic [1:0][31:0] wdata, odata;
  logic [1:0][3:0]  usage;

  int total = 0;
  int bad   = 0;

  // Model: allocation-ordered tag list plus per-tag done flag and payload.
  int          ord   [2][8];
  int          cnt   [2];
  bit          mdone [2][8];
  logic [31:0] mdat  [2][8];
  int          ap    [2];
  int          cap   [2] = '{8, 5};
  bit          fbw   [2] = '{1'b0, 1'b1};

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    id_reorder_buffer #(.CAPACITY(g == 0 ? 8 : 5), .FULL_BW(g == 1)) u_dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .alloc_req_i (req[g]),
      .alloc_gnt_o (gnt[g]),
      .alloc_tag_o (atag[g]),
      .wr_valid_i  (wr[g]),
      .wr_tag_i    (wtag[g]),
      .wr_data_i   (wdata[g]),
      .wr_err_o    (err[g]),
      .oup_valid_o (ovld[g]),
      .oup_ready_i (ready[g]),
      .oup_tag_o   (otag[g]),
      .oup_data_o  (odata[g]),
      .usage_o     (usage[g]),
      .full_o      (full[g]),
      .empty_o     (empty[g])
    );
  end

  task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
    end
  endtask

  function automatic bit inq(input int d, input int t);
    for (int i = 0; i < cnt[d]; i++) if (ord[d][i] == t) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      cnt[d] = 0;
      ap[d]  = 0;
      for (int i = 0; i < 8; i++) mdone[d][i] = 1'b0;
    end
  endtask

  task automatic model_step(input int d);
    int u, ht, wt;
    bit fl, em, v, pop, g, legal, e;
    logic [31:0] od;
    u  = cnt[d];
    fl = (u == cap[d]);
    em = (u == 0);
    ht = em ? ap[d] : ord[d][0];
    v  = !em && mdone[d][ht];
    od = v ? mdat[d][ht] : 32'h0;
    pop = v && ready[d];
    g  = req[d] && (!fl || (fbw[d] && pop));
    wt = int'(wtag[d]);
    legal = (wt < cap[d]) && inq(d, wt) && !mdone[d][wt];
    e  = wr[d] && !legal;
    chk($sformatf("d%0d_gnt", d),   32'(gnt[d]),   32'(g));
    chk($sformatf("d%0d_atag", d),  32'(atag[d]),  32'(ap[d]));
    chk($sformatf("d%0d_err", d),   32'(err[d]),   32'(e));
    chk($sformatf("d%0d_valid", d), 32'(ovld[d]),  32'(v));
    chk($sformatf("d%0d_otag", d),  32'(otag[d]),  32'(ht));
    chk($sformatf("d%0d_odata", d), odata[d],      od);
    chk($sformatf("d%0d_usage", d), 32'(usage[d]), 32'(u));
    chk($sformatf("d%0d_full", d),  32'(full[d]),  32'(fl));
    chk($sformatf("d%0d_empty", d), 32'(empty[d]), 32'(em));
    if (wr[d] && legal) begin
      mdone[d][wt] = 1'b1;
      mdat[d][wt]  = wdata[d];
    end
    if (pop) begin
      mdone[d][ht] = 1'b0;
      for (int i = 0; i < 7; i++) ord[d][i] = ord[d][i+1];
      cnt[d]--;
    end
    if (g) begin
      ord[d][cnt[d]] = ap[d];
      cnt[d]++;
      mdone[d][ap[d]] = 1'b0;
      ap[d] = (ap[d] + 1) % cap[d];
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    for (int d = 0; d < 2; d++) model_step(d);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req = '0; wr = '0; ready = '0; wtag = '0; wdata = '0;
  endtask

  task automatic drain(input int d);
    ready[d] = 1'b1;
    for (int i = 0; i < 40 && cnt[d] > 0; i++) begin
      if (!mdone[d][ord[d][0]]) begin
        wr[d] = 1'b1; wtag[d] = 3'(ord[d][0]); wdata[d] = $urandom;
      end else wr[d] = 1'b0;
      cyc();
    end
    wr[d] = 1'b0; ready[d] = 1'b0;
    chk($sformatf("d%0d_drain_usage", d), 32'(usage[d]), 32'd0);
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_usage", 32'(usage[0]), 32'd0);
    chk("rst_empty", 32'(empty[0]), 32'd1);
    chk("rst_valid", 32'(ovld[0]),  32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // In-order drain of out-of-order completions (dut 0).
    req[0] = 1'b1; ready[0] = 1'b1;
    repeat (3) cyc();
    req[0] = 1'b0; #1;
    chk("t1_usage3", 32'(usage[0]), 32'd3);
    wr[0] = 1'b1; wtag[0] = 3'd2; wdata[0] = 32'hC; cyc();
    wtag[0] = 3'd0; wdata[0] = 32'hA; cyc();
    wtag[0] = 3'd1; wdata[0] = 32'hB; #1;
    chk("t1_first_valid", 32'(ovld[0]), 32'd1);
    chk("t1_first_data", odata[0], 32'hA);
    cyc();
    wr[0] = 1'b0; #1;
    chk("t1_second_data", odata[0], 32'hB);
    cyc();
    chk("t1_third_data", odata[0], 32'hC);
    cyc();
    chk("t1_usage0", 32'(usage[0]), 32'd0);

    // Fill CAPACITY=5, refuse a sixth, drain, then observe tag wrap (dut 1).
    req[1] = 1'b1;
    repeat (5) cyc();
    chk("t2_full", 32'(full[1]), 32'd1);
    chk("t2_sixth_gnt", 32'(gnt[1]), 32'd0);
    cyc();
    req[1] = 1'b0; ready[1] = 1'b1; wr[1] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wtag[1] = 3'(i); wdata[1] = 32'h100 + 32'(i); cyc();
    end
    wr[1] = 1'b0;
    repeat (2) cyc();
    chk("t2_usage0", 32'(usage[1]), 32'd0);
    req[1] = 1'b1; #1;
    chk("t2_wrap_tag0", 32'(atag[1]), 32'd0);
    cyc();
    chk("t2_wrap_tag1", 32'(atag[1]), 32'd1);
    cyc();

    // FULL_BW=1: pop and grant together when full (dut 1).
    repeat (3) cyc();
    req[1] = 1'b0; ready[1] = 1'b0;
    wr[1] = 1'b1; wtag[1] = 3'd0; wdata[1] = 32'h55; cyc();
    wr[1] = 1'b0; req[1] = 1'b1; ready[1] = 1'b1; #1;
    chk("t3_fbw_valid", 32'(ovld[1]), 32'd1);
    chk("t3_fbw_gnt", 32'(gnt[1]), 32'd1);
    chk("t3_fbw_tag", 32'(atag[1]), 32'(otag[1]));
    cyc();
    req[1] = 1'b0; ready[1] = 1'b0; #1;
    chk("t3_fbw_usage", 32'(usage[1]), 32'd5);
    chk("t3_fbw_notdone", 32'(ovld[1]), 32'd0);

    // FULL_BW=0: no grant while full even with a pop (dut 0).
    req[0] = 1'b1;
    repeat (8) cyc();
    req[0] = 1'b0;
    wr[0] = 1'b1; wtag[0] = 3'd3; wdata[0] = 32'h33; cyc();
    wr[0] = 1'b0; req[0] = 1'b1; ready[0] = 1'b1; #1;
    chk("t4_nofbw_gnt", 32'(gnt[0]), 32'd0);
    cyc();
    req[0] = 1'b0; ready[0] = 1'b0; #1;
    chk("t4_usage7", 32'(usage[0]), 32'd7);

    // Illegal writes.
    wr[0] = 1'b1; wtag[0] = 3'd3; wdata[0] = 32'hDEAD; #1;
    chk("t5_unalloc_err", 32'(err[0]), 32'd1);
    cyc();
    wtag[0] = 3'd0; wdata[0] = 32'h1111; cyc();
    wdata[0] = 32'h2222; #1;
    chk("t5_double_err", 32'(err[0]), 32'd1);
    cyc();
    req[0] = 1'b1; wtag[0] = 3'd3; wdata[0] = 32'hBEEF; #1;
    chk("t5_same_alloc_err", 32'(err[0]), 32'd1);
    chk("t5_same_alloc_gnt", 32'(gnt[0]), 32'd1);
    cyc();
    idle();
    wr[1] = 1'b1; wtag[1] = 3'd6; #1;
    chk("t5_range_err", 32'(err[1]), 32'd1);
    cyc();
    wr[1] = 1'b0;
    drain(0);
    drain(1);

    // Asynchronous reset with outstanding tags (dut 0).
    req[0] = 1'b1; repeat (4) cyc();
    req[0] = 1'b0;
    wr[0] = 1'b1; wtag[0] = 3'(ord[0][0]); wdata[0] = 32'h77; cyc();
    wtag[0] = 3'(ord[0][1]); cyc();
    wr[0] = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #2;
    rst_n = 1'b1;
    #1;
    chk("t6_usage", 32'(usage[0]), 32'd0);
    chk("t6_empty", 32'(empty[0]), 32'd1);
    chk("t6_valid", 32'(ovld[0]), 32'd0);
    wr[0] = 1'b1; wtag[0] = 3'd1; #1;
    chk("t6_stale_err", 32'(err[0]), 32'd1);
    cyc();
    wr[0] = 1'b0; req[0] = 1'b1; #1;
    chk("t6_tag0", 32'(atag[0]), 32'd0);

    // Head-of-line blocking (dut 0, tags 0..3).
    repeat (4) cyc();
    req[0] = 1'b0; wr[0] = 1'b1;
    for (int i = 1; i < 4; i++) begin
      wtag[0] = 3'(i); wdata[0] = 32'h200 + 32'(i); cyc();
    end
    wr[0] = 1'b0; #1;
    chk("t7_hol_blocked", 32'(ovld[0]), 32'd0);
    cyc();
    wr[0] = 1'b1; wtag[0] = 3'd0; wdata[0] = 32'h200; ready[0] = 1'b1; cyc();
    wr[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t7_pop%0d_valid", i), 32'(ovld[0]), 32'd1);
      chk($sformatf("t7_pop%0d_data", i), odata[0], 32'h200 + 32'(i));
      cyc();
    end
    chk("t7_empty", 32'(empty[0]), 32'd1);
    idle();

    // Randomized traffic on both instances.
    for (int n = 0; n < 600; n++) begin
      for (int d = 0; d < 2; d++) begin
        req[d]   = 1'($urandom_range(0, 1));
        ready[d] = ($urandom_range(0, 3) != 0);
        wr[d]    = 1'($urandom_range(0, 1));
        wdata[d] = $urandom;
        if (cnt[d] > 0 && $urandom_range(0, 3) != 0)
          wtag[d] = 3'(ord[d][$urandom_range(0, cnt[d] - 1)]);
        else
          wtag[d] = 3'($urandom_range(0, 7));
      end
      cyc();
    end
    idle();
    drain(0);
    drain(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
